// File: rtl/inst_fetch_queue.sv
// Show-ahead {pc, inst} FIFO between IF and ID, flushed by a taken branch.
// Define FQ_BYPASS_EN to present fetched instructions combinationally when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_inst,
  output logic                     fq_full,
  input  logic                     flush,
  input  logic                     id_stall,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          nonempty;
  logic          bypass;
  logic          bypass_take;
  logic          push;
  logic          pop;

  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];
  assign fq_full  = (count == CW'(DEPTH));
  assign fq_count = count;

`ifdef FQ_BYPASS_EN
  assign bypass = ~nonempty & if_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry that ID accepts is consumed without ever touching storage.
  assign bypass_take = bypass & ~id_stall;
  assign push        = if_valid & ~fq_full & ~flush & ~bypass_take;
  assign pop         = nonempty & ~id_stall & ~flush;

  assign id_valid = nonempty | bypass;

  always_comb begin
    id_pc   = '0;
    id_inst = NOP_INST;
    if (nonempty) begin
      id_pc   = head[63:32];
      id_inst = head[31:0];
    end else if (bypass) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {if_pc, if_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fq_full;
  logic        flush;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  fq_count;

  inst_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .fq_full(fq_full), .flush(flush), .id_stall(id_stall), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .fq_count(fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit [63:0] q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
`ifdef FQ_BYPASS_EN
    return (q.size() == 0) && if_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_check();
    bit          byp;
    logic [31:0] epc;
    logic [31:0] einst;
    byp   = model_bypass();
    epc   = 32'h0;
    einst = NOP;
    if (q.size() != 0) begin
      epc   = q[0][63:32];
      einst = q[0][31:0];
    end else if (byp) begin
      epc   = if_pc;
      einst = if_inst;
    end
    chk("model_valid", {31'b0, id_valid}, {31'b0, (q.size() != 0) || byp});
    chk("model_pc", id_pc, epc);
    chk("model_inst", id_inst, einst);
    chk("model_full", {31'b0, fq_full}, {31'b0, q.size() == DEPTH});
    chk("model_count", {29'b0, fq_count}, q.size());
  endtask

  // Apply inputs shortly after a rising edge, then check once they have settled.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl, input logic r);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_stall = st;
    flush    = fl;
    rst      = r;
    #3;
    model_check();
  endtask

  task automatic tick();
    bit byp_take;
    bit consume;
    bit accept;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      byp_take = model_bypass() && !id_stall;
      consume  = (q.size() != 0) && !id_stall;
      accept   = if_valid && (q.size() < DEPTH) && !byp_take;
      if (consume) void'(q.pop_front());
      if (accept) q.push_back({if_pc, if_inst});
    end
    #1;
  endtask

  initial begin
    logic [31:0] ifpc;
    bit v, st, fl, r, acc;

    if_valid = 1'b0; if_pc = '0; if_inst = '0; id_stall = 1'b0; flush = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();

    // Reset then idle
    drive(0, 0, 0, 0, 0, 0);
    chk("reset_valid", {31'b0, id_valid}, 32'd0);
    chk("reset_inst", id_inst, 32'h0000_0013);
    chk("reset_pc", id_pc, 32'h0);
    chk("reset_full", {31'b0, fq_full}, 32'd0);
    chk("reset_count", {29'b0, fq_count}, 32'd0);
    tick();

    // Stream without stall
    drive(1, 32'h00, 32'hA0, 0, 0, 0);
`ifdef FQ_BYPASS_EN
    chk("byp_stream_pc", id_pc, 32'h00);
    chk("byp_stream_count", {29'b0, fq_count}, 32'd0);
`endif
    tick();
    drive(1, 32'h04, 32'hA1, 0, 0, 0);
`ifndef FQ_BYPASS_EN
    chk("stream_inst0", id_inst, 32'hA0);
`endif
    tick();
    drive(1, 32'h08, 32'hA2, 0, 0, 0);
`ifndef FQ_BYPASS_EN
    chk("stream_inst1", id_inst, 32'hA1);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 0);
`ifndef FQ_BYPASS_EN
    chk("stream_inst2", id_inst, 32'hA2);
    chk("stream_count", {29'b0, fq_count}, 32'd1);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("stream_empty", {31'b0, id_valid}, 32'd0);
    tick();

    // Fill under stall, refuse the fifth, then drain across the wrap
    for (int k = 0; k < 4; k++) begin
      drive(1, k * 4, inst_of(k * 4), 1, 0, 0);
      tick();
    end
    drive(1, 32'h10, inst_of(32'h10), 1, 0, 0);
    chk("fill_full", {31'b0, fq_full}, 32'd1);
    chk("fill_count", {29'b0, fq_count}, 32'd4);
    tick();
    drive(1, 32'h10, inst_of(32'h10), 0, 0, 0);
    chk("full_pop_pc", id_pc, 32'h00);
    chk("full_pop_full", {31'b0, fq_full}, 32'd1);
    tick();
    drive(1, 32'h10, inst_of(32'h10), 0, 0, 0);
    chk("after_pop_full", {31'b0, fq_full}, 32'd0);
    chk("after_pop_count", {29'b0, fq_count}, 32'd3);
    chk("after_pop_pc", id_pc, 32'h04);
    tick();
    for (int k = 2; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("drain_pc", id_pc, k * 4);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("drain_empty", {31'b0, id_valid}, 32'd0);
    tick();

    // Simultaneous push and pop at count 2
    drive(1, 32'h20, inst_of(32'h20), 1, 0, 0); tick();
    drive(1, 32'h24, inst_of(32'h24), 1, 0, 0); tick();
    drive(1, 32'h28, inst_of(32'h28), 0, 0, 0);
    chk("pp_count0", {29'b0, fq_count}, 32'd2);
    chk("pp_pc0", id_pc, 32'h20);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pp_count1", {29'b0, fq_count}, 32'd2);
    chk("pp_pc1", id_pc, 32'h24);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pp_pc2", id_pc, 32'h28);
    tick();

    // Flush with entries queued and a same-cycle fetch
    drive(1, 32'h30, inst_of(32'h30), 1, 0, 0); tick();
    drive(1, 32'h34, inst_of(32'h34), 1, 0, 0); tick();
    drive(1, 32'h38, inst_of(32'h38), 1, 0, 0); tick();
    drive(1, 32'h40, inst_of(32'h40), 0, 1, 0);
    chk("flush_pre_count", {29'b0, fq_count}, 32'd3);
    tick();
    drive(1, 32'h80, inst_of(32'h80), 1, 0, 0);
`ifndef FQ_BYPASS_EN
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
`endif
    chk("flush_count", {29'b0, fq_count}, 32'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("redirect_valid", {31'b0, id_valid}, 32'd1);
    chk("redirect_pc", id_pc, 32'h80);
    chk("redirect_count", {29'b0, fq_count}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0); tick();

`ifdef FQ_BYPASS_EN
    drive(1, 32'h100, inst_of(32'h100), 0, 0, 0);
    chk("byp_valid", {31'b0, id_valid}, 32'd1);
    chk("byp_pc", id_pc, 32'h100);
    chk("byp_count", {29'b0, fq_count}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("byp_after_count", {29'b0, fq_count}, 32'd0);
    tick();
    drive(1, 32'h100, inst_of(32'h100), 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0);
    chk("byp_stall_count", {29'b0, fq_count}, 32'd1);
    chk("byp_stall_pc", id_pc, 32'h100);
    tick();
    drive(0, 0, 0, 0, 0, 0); tick();
`endif

    // Random traffic with an IF stage that retries refused fetches
    ifpc = 32'h1000;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 9) < 4);
      drive(v, ifpc, inst_of(ifpc), st, fl, r);
      acc = v && !fl && !r && (q.size() < DEPTH);
      tick();
      if (fl || r) ifpc = {18'b0, 12'($urandom_range(0, 4095)), 2'b00};
      else if (acc) ifpc = ifpc + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
